// File: rtl/mic_pkg.sv
// ============================================================================
//  Module  : mic_pkg
//  Brief   : Shared types and default widths for the microphone tick generator
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mic_pkg;

    typedef enum logic {
        MIC_MODE_ALT = 1'b0,
        MIC_MODE_ACC = 1'b1
    } mic_mode_t;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } mic_phase_t;

    localparam int c_acc_w = 16;
    localparam int c_cnt_w = 8;
    localparam int c_dec_w = 8;

endpackage

`default_nettype wire

// File: rtl/mic_period_core.sv
// ============================================================================
//  Module  : mic_period_core
//  Brief   : Alternating two-period counter and phase accumulator; emits the
//            combinational terminal-event strobe consumed by the tick logic.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mic_period_core
    import mic_pkg::*;
#(
    parameter int ACC_W = c_acc_w,
    parameter int CNT_W = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  mic_mode_t        i_mode,
    input  logic [CNT_W-1:0] i_per_a,
    input  logic [CNT_W-1:0] i_per_b,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_evt
);

    logic [CNT_W-1:0] r_cnt;
    mic_phase_t       r_phase;
    logic [ACC_W-1:0] r_acc;

    logic [CNT_W-1:0] w_per;
    logic [CNT_W-1:0] w_last;
    logic [ACC_W:0]   w_sum;
    logic             w_alt_evt;

    // A zero period behaves like a period of one: terminal count is 0.
    always_comb begin
        w_per     = (r_phase == PH_A) ? i_per_a : i_per_b;
        w_last    = (w_per == '0) ? '0 : w_per - CNT_W'(1);
        w_sum     = {1'b0, r_acc} + {1'b0, i_inc};
        w_alt_evt = (r_cnt == w_last);
        o_evt     = i_en && ((i_mode == MIC_MODE_ACC) ? w_sum[ACC_W] : w_alt_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= PH_A;
            r_acc   <= '0;
        end else if (!i_en || i_clr) begin
            r_cnt   <= '0;
            r_phase <= PH_A;
            r_acc   <= '0;
        end else if (i_mode == MIC_MODE_ACC) begin
            r_acc   <= w_sum[ACC_W-1:0];
        end else if (w_alt_evt) begin
            r_cnt   <= '0;
            r_phase <= (r_phase == PH_A) ? PH_B : PH_A;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mic_tick_gen.sv
// ============================================================================
//  Module  : mic_tick_gen
//  Brief   : Mic bit tick, 50% mic clock and decimated sample strobe with
//            double-buffered configuration applied on tick boundaries.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mic_tick_gen
    import mic_pkg::*;
#(
    parameter int ACC_W     = c_acc_w,
    parameter int CNT_W     = c_cnt_w,
    parameter int DEC_W     = c_dec_w,
    parameter int RST_MODE  = 0,
    parameter int RST_PER_A = 17,
    parameter int RST_PER_B = 16,
    parameter int RST_INC   = 0,
    parameter int RST_DECIM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic             cfg_mode,
    input  logic [CNT_W-1:0] cfg_per_a,
    input  logic [CNT_W-1:0] cfg_per_b,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [DEC_W-1:0] cfg_decim,
    output logic             cfg_pending,
    output logic             tick,
    output logic             mic_clk,
    output logic             sample_tick
);

    mic_mode_t        r_pend_mode;
    logic [CNT_W-1:0] r_pend_per_a;
    logic [CNT_W-1:0] r_pend_per_b;
    logic [ACC_W-1:0] r_pend_inc;
    logic [DEC_W-1:0] r_pend_decim;

    mic_mode_t        r_act_mode;
    logic [CNT_W-1:0] r_act_per_a;
    logic [CNT_W-1:0] r_act_per_b;
    logic [ACC_W-1:0] r_act_inc;
    logic [DEC_W-1:0] r_act_decim;

    logic             r_cfg_pending;
    logic             r_tick;
    logic             r_mic_clk;
    logic             r_sample_tick;
    logic [DEC_W-1:0] r_dcnt;

    logic             w_evt;
    logic             w_apply;
    logic [DEC_W-1:0] w_dec_last;
    logic [DEC_W-1:0] w_dcnt_nxt;
    logic             w_sample_nxt;

    mic_period_core #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en),
        .i_clr   (w_apply),
        .i_mode  (r_act_mode),
        .i_per_a (r_act_per_a),
        .i_per_b (r_act_per_b),
        .i_inc   (r_act_inc),
        .o_evt   (w_evt)
    );

    // Pending config swaps in on a terminal event, or immediately when idle.
    assign w_apply = r_cfg_pending && (!en || w_evt);

    // The sample decision uses the outgoing config; the counter restarts on apply.
    always_comb begin
        w_dec_last   = (r_act_decim == '0) ? '0 : r_act_decim - DEC_W'(1);
        w_dcnt_nxt   = r_dcnt;
        w_sample_nxt = 1'b0;
        if (w_evt) begin
            if (r_dcnt == w_dec_last) begin
                w_sample_nxt = 1'b1;
                w_dcnt_nxt   = '0;
            end else begin
                w_dcnt_nxt   = r_dcnt + DEC_W'(1);
            end
        end
        if (!en || w_apply) begin
            w_dcnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_mode   <= (RST_MODE != 0) ? MIC_MODE_ACC : MIC_MODE_ALT;
            r_pend_per_a  <= CNT_W'(RST_PER_A);
            r_pend_per_b  <= CNT_W'(RST_PER_B);
            r_pend_inc    <= ACC_W'(RST_INC);
            r_pend_decim  <= DEC_W'(RST_DECIM);
            r_act_mode    <= (RST_MODE != 0) ? MIC_MODE_ACC : MIC_MODE_ALT;
            r_act_per_a   <= CNT_W'(RST_PER_A);
            r_act_per_b   <= CNT_W'(RST_PER_B);
            r_act_inc     <= ACC_W'(RST_INC);
            r_act_decim   <= DEC_W'(RST_DECIM);
            r_cfg_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_mode  <= r_pend_mode;
                r_act_per_a <= r_pend_per_a;
                r_act_per_b <= r_pend_per_b;
                r_act_inc   <= r_pend_inc;
                r_act_decim <= r_pend_decim;
            end
            if (cfg_wr) begin
                r_pend_mode   <= cfg_mode ? MIC_MODE_ACC : MIC_MODE_ALT;
                r_pend_per_a  <= cfg_per_a;
                r_pend_per_b  <= cfg_per_b;
                r_pend_inc    <= cfg_inc;
                r_pend_decim  <= cfg_decim;
                r_cfg_pending <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick        <= 1'b0;
            r_mic_clk     <= 1'b0;
            r_sample_tick <= 1'b0;
            r_dcnt        <= '0;
        end else begin
            r_tick        <= w_evt;
            r_mic_clk     <= en ? (r_mic_clk ^ w_evt) : 1'b0;
            r_sample_tick <= w_sample_nxt;
            r_dcnt        <= w_dcnt_nxt;
        end
    end

    assign cfg_pending = r_cfg_pending;
    assign tick        = r_tick;
    assign mic_clk     = r_mic_clk;
    assign sample_tick = r_sample_tick;

endmodule

`default_nettype wire

// File: tb/tb_mic_tick_gen.sv
// ============================================================================
//  Module  : tb_mic_tick_gen
//  Brief   : Self-checking bench for mic_tick_gen against a behavioural model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mic_tick_gen;

    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam int DEC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             cfg_wr = 1'b0;
    logic             cfg_mode = 1'b0;
    logic [CNT_W-1:0] cfg_per_a = '0;
    logic [CNT_W-1:0] cfg_per_b = '0;
    logic [ACC_W-1:0] cfg_inc = '0;
    logic [DEC_W-1:0] cfg_decim = '0;
    logic             cfg_pending;
    logic             tick;
    logic             mic_clk;
    logic             sample_tick;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mic_tick_gen #(
        .ACC_W(ACC_W), .CNT_W(CNT_W), .DEC_W(DEC_W),
        .RST_MODE(0), .RST_PER_A(17), .RST_PER_B(16), .RST_INC(0), .RST_DECIM(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_wr      (cfg_wr),
        .cfg_mode    (cfg_mode),
        .cfg_per_a   (cfg_per_a),
        .cfg_per_b   (cfg_per_b),
        .cfg_inc     (cfg_inc),
        .cfg_decim   (cfg_decim),
        .cfg_pending (cfg_pending),
        .tick        (tick),
        .mic_clk     (mic_clk),
        .sample_tick (sample_tick)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: events are derived from elapsed enabled edges since
    // the last restart, not from a counter/phase register image.
    typedef struct {
        longint mode;
        longint pa;
        longint pb;
        longint inc;
        longint dec;
    } cfg_t;

    cfg_t   m_act, m_pend;
    bit     m_pending, m_tick, m_mic, m_sample, m_ev, m_app, m_phb;
    longint m_n, m_next, m_ticks;

    function automatic longint eff(input longint v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic m_restart();
        m_n     = 0;
        m_phb   = 0;
        m_next  = eff(m_act.pa);
        m_ticks = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act     = '{0, 17, 16, 0, 1};
            m_pend    = m_act;
            m_pending = 0;
            m_tick    = 0;
            m_mic     = 0;
            m_sample  = 0;
            m_restart();
        end else begin
            m_ev = 0;
            if (en) begin
                m_n++;
                if (m_act.mode == 1) begin
                    m_ev = ((m_n * m_act.inc) >> ACC_W) != (((m_n - 1) * m_act.inc) >> ACC_W);
                end else if (m_n == m_next) begin
                    m_ev   = 1;
                    m_phb  = !m_phb;
                    m_next = m_next + eff(m_phb ? m_act.pb : m_act.pa);
                end
            end
            m_sample = 0;
            if (m_ev) begin
                m_ticks++;
                if ((m_ticks % eff(m_act.dec)) == 0) m_sample = 1;
            end
            m_tick = m_ev;
            m_mic  = en ? (m_mic ^ m_ev) : 1'b0;
            m_app  = m_pending && (!en || m_ev);
            if (m_app) m_act = m_pend;
            if (m_app || !en) m_restart();
            if (cfg_wr) begin
                m_pend    = '{longint'(cfg_mode), longint'(cfg_per_a), longint'(cfg_per_b),
                              longint'(cfg_inc), longint'(cfg_decim)};
                m_pending = 1;
            end else if (m_app) begin
                m_pending = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("tick", tick, m_tick);
            chk("mic_clk", mic_clk, m_mic);
            chk("sample_tick", sample_tick, m_sample);
            chk("cfg_pending", cfg_pending, m_pending);
        end
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_cfg(input bit mode, input int pa, input int pb, input int inc, input int dec);
        cfg_mode  = mode;
        cfg_per_a = CNT_W'(pa);
        cfg_per_b = CNT_W'(pb);
        cfg_inc   = ACC_W'(inc);
        cfg_decim = DEC_W'(dec);
    endtask

    // Idle write then idle apply; leaves en low and config active.
    task automatic apply_idle(input bit mode, input int pa, input int pb, input int inc, input int dec);
        en = 0;
        cfg_wr = 1;
        drive_cfg(mode, pa, pb, inc, dec);
        cyc(1);
        cfg_wr = 0;
        cyc(1);
        chk("idle_apply_pending", cfg_pending, 0);
    endtask

    task automatic check_first_ticks(input string tag);
        int t[$];
        for (int c = 1; c <= 70; c++) begin
            cyc(1);
            if (tick) t.push_back(c);
        end
        chk({tag, "_t0"}, (t.size() > 0) ? t[0] : -1, 17);
        chk({tag, "_t1"}, (t.size() > 1) ? t[1] : -1, 33);
        chk({tag, "_t2"}, (t.size() > 2) ? t[2] : -1, 50);
        chk({tag, "_t3"}, (t.size() > 3) ? t[3] : -1, 66);
    endtask

    task automatic wait_tick(input string tag, input int budget, output int waited);
        waited = -1;
        for (int k = 1; k <= budget; k++) begin
            cyc(1);
            if (tick) begin
                waited = k;
                break;
            end
        end
        n_tests++;
        if (waited < 0) begin
            n_fail++;
            $display("FAIL %s: no tick within %0d cycles, expected one", tag, budget);
        end
    endtask

    initial begin
        int w, cnt, first;
        #1;
        cyc(3);
        chk("rst_tick", tick, 0);
        chk("rst_mic_clk", mic_clk, 0);
        chk("rst_sample", sample_tick, 0);
        chk("rst_pending", cfg_pending, 0);

        // Default alternating 17/16 timing from reset release
        rst_n = 1;
        en    = 1;
        check_first_ticks("s1");
        cyc(130);

        // Switch to accumulator mode while running; applies on next tick
        cfg_wr = 1;
        drive_cfg(1, 17, 16, 16'h4000, 1);
        cyc(1);
        cfg_wr = 0;
        chk("s2_pending_set", cfg_pending, 1);
        wait_tick("s2_apply", 40, w);
        chk("s2_pending_clear", cfg_pending, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("s2_spacing4", tick, (i % 4) == 0);
        end

        // Long-run accumulator rate: floor(32768 * 0x5555 / 65536) = 10922
        apply_idle(1, 17, 16, 16'h5555, 1);
        en  = 1;
        cnt = 0;
        for (int i = 0; i < 32768; i++) begin
            cyc(1);
            if (tick) cnt++;
        end
        chk("s2_acc_count", cnt, 10922);

        // Decimate by 4 with alternating 5/5
        apply_idle(0, 5, 5, 0, 4);
        en    = 1;
        cnt   = 0;
        first = -1;
        for (int c = 1; c <= 100; c++) begin
            cyc(1);
            if (sample_tick) begin
                cnt++;
                if (first < 0) first = c;
            end
        end
        chk("s3_first_sample", first, 20);
        chk("s3_sample_count", cnt, 5);

        // Two writes before apply: last write wins
        wait_tick("s4_sync", 10, w);
        cfg_wr = 1;
        drive_cfg(0, 7, 7, 0, 1);
        cyc(1);
        drive_cfg(0, 3, 3, 0, 1);
        cyc(1);
        cfg_wr = 0;
        wait_tick("s4_apply", 10, w);
        chk("s4_pending_clear", cfg_pending, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk("s4_spacing3", tick, (i % 3) == 0);
        end

        // Write on the apply edge keeps pending set; a further apply follows
        en = 0;
        cfg_wr = 1;
        drive_cfg(0, 4, 6, 0, 2);
        cyc(1);
        drive_cfg(0, 9, 9, 0, 1);
        cyc(1);
        cfg_wr = 0;
        chk("s4_pending_kept", cfg_pending, 1);
        cyc(1);
        chk("s4_pending_done", cfg_pending, 0);
        en = 1;
        wait_tick("s4_second_cfg", 30, w);
        chk("s4_second_cfg_period", w, 9);

        // Enable drop mid-period
        cyc(4);
        en = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("s5_idle_tick", tick, 0);
            chk("s5_idle_mic", mic_clk, 0);
        end
        en = 1;
        wait_tick("s5_restart", 30, w);
        chk("s5_restart_period", w, 9);

        // Asynchronous reset between edges, with a pending write in flight
        cyc(2);
        cfg_wr = 1;
        drive_cfg(0, 2, 2, 0, 1);
        cyc(1);
        cfg_wr = 0;
        #3;
        rst_n = 0;
        #1;
        chk("s6_async_tick", tick, 0);
        chk("s6_async_mic", mic_clk, 0);
        chk("s6_async_sample", sample_tick, 0);
        chk("s6_async_pending", cfg_pending, 0);
        cyc(2);
        rst_n = 1;
        check_first_ticks("s6");

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            en     = ($urandom_range(0, 19) != 0);
            cfg_wr = ($urandom_range(0, 29) == 0);
            drive_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 8), $urandom_range(0, 8),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535) : $urandom_range(0, 4095),
                      $urandom_range(0, 5));
            cyc(1);
        end
        cfg_wr = 0;
        en     = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
